// File: rtl/adder_issue_arbiter_pkg.sv
// Shared types and helpers for the adder issue arbiter.
// Two-bit kill/propagate/generate carry codes and their prefix operator.
package adder_issue_pkg;

    localparam int WIDTH = 32;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KILL = 2'b00;
    localparam kpg_t PROP = 2'b01;
    localparam kpg_t GEN  = 2'b11;

    function automatic kpg_t kpg_encode(
        input logic a_bit,
        input logic b_bit
    );
        kpg_t r;
        unique case ({a_bit, b_bit})
            2'b00:   r = KILL;
            2'b11:   r = GEN;
            default: r = PROP;
        endcase
        return r;
    endfunction

    // A propagating upper span passes the lower span's code through.
    function automatic kpg_t kpg_combine(
        input kpg_t hi,
        input kpg_t lo
    );
        return (hi == PROP) ? lo : hi;
    endfunction

endpackage

// File: rtl/adder_issue_arbiter_if.sv
// Request/result handshake bundle between requesters,
// the shared adder and writeback.
interface adder_issue_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic [ID_W-1:0]       res_id;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output req_cin,
        output res_ready,
        input  req_ready,
        input  res_valid,
        input  res_sum,
        input  res_cout,
        input  res_id
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  req_cin,
        input  res_ready,
        output req_ready,
        output res_valid,
        output res_sum,
        output res_cout,
        output res_id
    );

endinterface

// File: rtl/adder_issue_arbiter_prefix_carry_core.sv
// 32-lane carry-generation prefix network (Kogge-Stone).
// Lane 0 holds the carry-in code, so every lane resolves to GEN/KILL.
module prefix_carry_core
    import adder_issue_pkg::*;
(
    input  logic [WIDTH-1:0][1:0] kpg_i,
    output logic [WIDTH-1:0]      carry_o
);

    logic [WIDTH-1:0][1:0] lvl;

    // Descending lane order lets each level update in place.
    always_comb begin
        lvl = kpg_i;
        for (int l = 0; l < 5; l++) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i >= (1 << l)) begin
                    lvl[i] = kpg_combine(lvl[i], lvl[i - (1 << l)]);
                end
            end
        end
        carry_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_o[i] = lvl[i][1];
        end
    end

endmodule

// File: rtl/adder_issue_arbiter.sv
// Round-robin arbiter sharing one carry-prefix adder among requesters,
// with an issue stage (S1) and a result stage (S2).
module adder_issue_arbiter
    import adder_issue_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    adder_issue_arbiter_if.slave bus,
    output logic                busy
);

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_cin_q, s1_cin_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    logic             s2_cout_q, s2_cout_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic             s2_adv;
    logic             s1_free;
    logic             found;
    logic [ID_W-1:0]  gnt_id;
    logic [NREQ-1:0]  gnt;
    logic             xfer;
    int               idx;

    logic [WIDTH-1:0][1:0] kpg;
    logic [WIDTH-1:0]      carry;
    logic [WIDTH-1:0]      sum;
    logic                  cout;

    assign s2_adv  = s1_v_q & (~s2_v_q | bus.res_ready);
    assign s1_free = ~s1_v_q | s2_adv;

    // Rotating scan starting at rr_ptr; operands never enter the grant.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found && s1_free && !rst) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    assign xfer = |(bus.req_valid & gnt);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (int'(gnt_id) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_id + 1'b1;
            end
        end
    end

    always_comb begin
        s1_v_d   = s1_v_q & ~s2_adv;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_cin_d = s1_cin_q;
        s1_id_d  = s1_id_q;
        if (xfer) begin
            s1_v_d   = 1'b1;
            s1_a_d   = bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
            s1_b_d   = bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
            s1_cin_d = bus.req_cin[gnt_id];
            s1_id_d  = gnt_id;
        end
    end

    // Lane i carries the code of bit i-1; lane 0 is the carry-in.
    always_comb begin
        kpg    = '0;
        kpg[0] = s1_cin_q ? GEN : KILL;
        for (int i = 1; i < WIDTH; i++) begin
            kpg[i] = kpg_encode(s1_a_q[i-1], s1_b_q[i-1]);
        end
    end

    prefix_carry_core u_prefix (
        .kpg_i   (kpg),
        .carry_o (carry)
    );

    assign sum  = s1_a_q ^ s1_b_q ^ carry;
    assign cout = (s1_a_q[WIDTH-1] & s1_b_q[WIDTH-1])
                | ((s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1]) & carry[WIDTH-1]);

    always_comb begin
        s2_v_d    = s2_v_q & ~bus.res_ready;
        s2_sum_d  = s2_sum_q;
        s2_cout_d = s2_cout_q;
        s2_id_d   = s2_id_q;
        if (s2_adv) begin
            s2_v_d    = 1'b1;
            s2_sum_d  = sum;
            s2_cout_d = cout;
            s2_id_d   = s1_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_cin_q  <= 1'b0;
            s1_id_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_sum_q  <= '0;
            s2_cout_q <= 1'b0;
            s2_id_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_cin_q  <= s1_cin_d;
            s1_id_q   <= s1_id_d;
            s2_v_q    <= s2_v_d;
            s2_sum_q  <= s2_sum_d;
            s2_cout_q <= s2_cout_d;
            s2_id_q   <= s2_id_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.res_valid = s2_v_q;
    assign bus.res_sum   = s2_sum_q;
    assign bus.res_cout  = s2_cout_q;
    assign bus.res_id    = s2_id_q;
    assign busy          = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_adder_issue_arbiter.sv
// Directed bench for adder_issue_arbiter: reset, single ops,
// round-robin, backpressure, carry extremes and mid-flight reset.
module tb_adder_issue_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adder_issue_arbiter_if #(.NREQ(4), .WIDTH(32), .ID_W(2)) bus ();

    adder_issue_arbiter #(.NREQ(4), .WIDTH(32), .ID_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic c);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_cin[i]        = c;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic run_op(input string tag, input int i,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] es,
                          input logic ec);
        set_op(i, a, b, c);
        bus.req_valid = 4'(1 << i);
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << i));
        tick();
        bus.req_valid = '0;
        #1;
        chk({tag, "_early"}, 32'(bus.res_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, "_sum"}, bus.res_sum, es);
        chk({tag, "_cout"}, 32'(bus.res_cout), 32'(ec));
        chk({tag, "_id"}, 32'(bus.res_id), 32'(i));
        tick();
        chk({tag, "_drain"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.res_ready = 1'b1;

        // reset holds everything quiet even with all requests up
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_valid", 32'(bus.res_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rst_first_grant", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        tick();

        run_op("single", 1, 32'h0000FFFF, 32'h00000001, 1'b0,
               32'h00010000, 1'b0);

        // round-robin with all requesters valid every cycle
        pulse_rst();
        for (int i = 0; i < 4; i++) set_op(i, 32'(i * 16), 32'd1, 1'b0);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            if (k > 0) begin
                chk("rr_valid", 32'(bus.res_valid), 32'd1);
                chk("rr_id", 32'(bus.res_id), 32'((k - 1) % 4));
                chk("rr_sum", bus.res_sum, 32'(((k - 1) % 4) * 16 + 1));
            end
        end
        bus.req_valid = '0;
        tick();
        chk("rr_last_id", 32'(bus.res_id), 32'd3);
        chk("rr_last_sum", bus.res_sum, 32'h31);
        tick();
        chk("rr_empty", 32'(bus.res_valid), 32'd0);

        // backpressure: three ops queued while writeback stalls
        pulse_rst();
        bus.res_ready = 1'b0;
        set_op(0, 32'h100, 32'h1, 1'b0);
        set_op(1, 32'h200, 32'h2, 1'b0);
        set_op(2, 32'h300, 32'h3, 1'b1);
        bus.req_valid = 4'b0111;
        #1;
        chk("bp_g0", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = 4'b0110;
        #1;
        chk("bp_g1", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        chk("bp_full_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_valid", 32'(bus.res_valid), 32'd1);
        chk("bp_id0", 32'(bus.res_id), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_hold_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_hold_sum", bus.res_sum, 32'h101);
            chk("bp_hold_id", 32'(bus.res_id), 32'd0);
            chk("bp_hold_busy", 32'(busy), 32'd1);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_release_g2", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = '0;
        chk("bp_r1_id", 32'(bus.res_id), 32'd1);
        chk("bp_r1_sum", bus.res_sum, 32'h202);
        tick();
        chk("bp_r2_id", 32'(bus.res_id), 32'd2);
        chk("bp_r2_sum", bus.res_sum, 32'h304);
        chk("bp_r2_valid", 32'(bus.res_valid), 32'd1);
        tick();
        chk("bp_end_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_end_busy", 32'(busy), 32'd0);

        run_op("c_ones_cin", 3, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1);
        run_op("c_msb", 0, 32'h80000000, 32'h80000000, 1'b0,
               32'h0, 1'b1);
        run_op("c_alt", 2, 32'hAAAAAAAA, 32'h55555555, 1'b1,
               32'h0, 1'b1);
        run_op("c_mix", 1, 32'h12345678, 32'h9ABCDEF0, 1'b0,
               32'hACF13568, 1'b0);
        run_op("c_max", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               32'hFFFFFFFF, 1'b1);
        run_op("c_zero", 2, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // reset with both stages occupied discards everything
        pulse_rst();
        bus.res_ready = 1'b0;
        set_op(0, 32'h1, 32'h1, 1'b0);
        set_op(1, 32'h2, 32'h2, 1'b0);
        bus.req_valid = 4'b0011;
        tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        #1;
        chk("mf_pre_busy", 32'(busy), 32'd1);
        chk("mf_pre_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("mf_valid", 32'(bus.res_valid), 32'd0);
        chk("mf_busy", 32'(busy), 32'd0);
        bus.req_valid = 4'b1111;
        #1;
        chk("mf_ptr0", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mf_no_stale", 32'(bus.res_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
